// File: rtl/beam_pkg.sv
// Shared beamformer constants and the scan FSM state type.
package beam_pkg;

  localparam int unsigned MIC_NUMBER  = 16;
  localparam int unsigned READBIT     = 16;
  localparam int unsigned ADD_SQ_W    = 35;
  localparam int unsigned N_ANGLE_DEF = 37;

  typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, DONE} scan_state_t;

endpackage

// File: rtl/beam_power_scan_if.sv
// Sample input stream plus per-angle power and best-angle result outputs.
interface beam_power_scan_if #(
  parameter int unsigned DATA_W = 35,
  parameter int unsigned ACC_W  = 45,
  parameter int unsigned ANG_W  = 6
);
  logic              i_start;
  logic              i_valid;
  logic [DATA_W-1:0] i_data;
  logic              o_ready;
  logic              o_busy;
  logic              o_pow_valid;
  logic [ANG_W-1:0]  o_pow_angle;
  logic [ACC_W-1:0]  o_pow_data;
  logic              o_done;
  logic [ANG_W-1:0]  o_best_angle;
  logic [ACC_W-1:0]  o_best_power;

  modport master (
    output i_start, i_valid, i_data,
    input  o_ready, o_busy, o_pow_valid, o_pow_angle, o_pow_data,
           o_done, o_best_angle, o_best_power
  );

  modport slave (
    input  i_start, i_valid, i_data,
    output o_ready, o_busy, o_pow_valid, o_pow_angle, o_pow_data,
           o_done, o_best_angle, o_best_power
  );
endinterface

// File: rtl/sat_accumulator.sv
// Unsigned accumulator that clamps at all-ones instead of wrapping.
// sum_c is the value the register takes on the next add.
module sat_accumulator #(
  parameter int unsigned DATA_W = 35,
  parameter int unsigned ACC_W  = 45
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              add_en,
  input  logic [DATA_W-1:0] din,
  output logic [ACC_W-1:0]  acc,
  output logic [ACC_W-1:0]  sum_c
);

  logic [ACC_W:0] raw_c;

  assign raw_c = {1'b0, acc} + (ACC_W+1)'(din);
  assign sum_c = raw_c[ACC_W] ? '1 : raw_c[ACC_W-1:0];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= sum_c;
    end
  end

endmodule

// File: rtl/beam_power_scan.sv
// Integrates squared beam power per steering angle over a scan, streams each
// angle's power and registers the strongest angle when the scan completes.
module beam_power_scan
  import beam_pkg::*;
#(
  parameter int unsigned N_ANGLE  = N_ANGLE_DEF,
  parameter int unsigned N_SAMPLE = 1024,
  parameter int unsigned DATA_W   = ADD_SQ_W,
  parameter int unsigned ACC_W    = DATA_W + $clog2(N_SAMPLE),
  parameter int unsigned ANG_W    = $clog2(N_ANGLE)
) (
  input logic              i_clk,
  input logic              i_rst,
  beam_power_scan_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(N_SAMPLE);

  scan_state_t      state;
  logic [ANG_W-1:0] angle;
  logic [CNT_W-1:0] smp;
  logic [ACC_W-1:0] best_run;
  logic [ANG_W-1:0] best_ang_run;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum_c;

  logic accept_c, last_smp_c, last_ang_c, new_best_c, start_ok_c, acc_clr_c;

  assign accept_c   = (state == ACCUM) && bus.i_valid;
  assign last_smp_c = (smp == CNT_W'(N_SAMPLE - 1));
  assign last_ang_c = (angle == ANG_W'(N_ANGLE - 1));
  assign new_best_c = (angle == '0) || (acc > best_run);
  assign start_ok_c = bus.i_start && ((state == IDLE) || (state == DONE));
  assign acc_clr_c  = start_ok_c || (state == COMPARE);

  sat_accumulator #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_acc (
    .clk    (i_clk),
    .rst    (i_rst),
    .clear  (acc_clr_c),
    .add_en (accept_c),
    .din    (bus.i_data),
    .acc    (acc),
    .sum_c  (acc_sum_c)
  );

  // Scan FSM; the final per-angle power is taken from the adder output so it
  // is published the cycle after the last sample is accepted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= IDLE;
      angle            <= '0;
      smp              <= '0;
      best_run         <= '0;
      best_ang_run     <= '0;
      bus.o_ready      <= 1'b0;
      bus.o_busy       <= 1'b0;
      bus.o_pow_valid  <= 1'b0;
      bus.o_pow_angle  <= '0;
      bus.o_pow_data   <= '0;
      bus.o_done       <= 1'b0;
      bus.o_best_angle <= '0;
      bus.o_best_power <= '0;
    end else begin
      bus.o_pow_valid <= 1'b0;
      bus.o_done      <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.i_start) begin
            state        <= ACCUM;
            angle        <= '0;
            smp          <= '0;
            best_run     <= '0;
            best_ang_run <= '0;
            bus.o_ready  <= 1'b1;
            bus.o_busy   <= 1'b1;
          end
        end
        ACCUM: begin
          if (accept_c) begin
            if (last_smp_c) begin
              state           <= COMPARE;
              smp             <= '0;
              bus.o_ready     <= 1'b0;
              bus.o_pow_valid <= 1'b1;
              bus.o_pow_angle <= angle;
              bus.o_pow_data  <= acc_sum_c;
            end else begin
              smp <= smp + CNT_W'(1);
            end
          end
        end
        COMPARE: begin
          if (new_best_c) begin
            best_run     <= acc;
            best_ang_run <= angle;
          end
          if (last_ang_c) begin
            state            <= DONE;
            bus.o_busy       <= 1'b0;
            bus.o_done       <= 1'b1;
            bus.o_best_angle <= new_best_c ? angle : best_ang_run;
            bus.o_best_power <= new_best_c ? acc : best_run;
          end else begin
            state       <= ACCUM;
            angle       <= angle + ANG_W'(1);
            bus.o_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_beam_power_scan.sv
// Scoreboard bench for beam_power_scan with a small scan (4 angles x 8 samples).
module tb_beam_power_scan;

  localparam int unsigned NA     = 4;
  localparam int unsigned NS     = 8;
  localparam int unsigned DW     = 35;
  localparam int unsigned AW     = 38;
  localparam int unsigned GW     = 2;
  localparam int unsigned SAT_AW = 36;

  typedef struct {
    logic [63:0] ang;
    logic [63:0] pw;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  beam_power_scan_if #(.DATA_W(DW), .ACC_W(AW), .ANG_W(GW)) bus ();
  beam_power_scan_if #(.DATA_W(DW), .ACC_W(SAT_AW), .ANG_W(GW)) bus_s ();

  beam_power_scan #(.N_ANGLE(NA), .N_SAMPLE(NS), .DATA_W(DW), .ACC_W(AW), .ANG_W(GW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  beam_power_scan #(.N_ANGLE(NA), .N_SAMPLE(NS), .DATA_W(DW), .ACC_W(SAT_AW), .ANG_W(GW)) dut_sat (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_s)
  );

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int unsigned done_cnt = 0;
  exp_t pq[$];
  exp_t bq[$];
  exp_t mon_e;
  logic [63:0] tgt [NA];
  logic [63:0] last_best_a = 0;
  logic [63:0] last_best_p = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Output monitor: pops the scoreboard on every power and done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_pow_valid || bus.o_done)
        check_eq("pv_done_excl", 64'(bus.o_pow_valid & bus.o_done), 0);
      if (bus.o_pow_valid) begin
        check_eq("pow_expected", 64'(pq.size() != 0), 1);
        if (pq.size() != 0) begin
          mon_e = pq.pop_front();
          check_eq("pow_angle", 64'(bus.o_pow_angle), mon_e.ang);
          check_eq("pow_data", 64'(bus.o_pow_data), mon_e.pw);
        end
      end
      if (bus.o_done) begin
        done_cnt++;
        check_eq("done_expected", 64'(bq.size() != 0), 1);
        if (bq.size() != 0) begin
          mon_e = bq.pop_front();
          check_eq("best_angle", 64'(bus.o_best_angle), mon_e.ang);
          check_eq("best_power", 64'(bus.o_best_power), mon_e.pw);
        end
      end
    end
  end

  task automatic push(input logic [63:0] v, input bit gap);
    int n;
    if (gap) begin
      bus.i_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    bus.i_valid = 1'b1;
    bus.i_data  = DW'(v);
    n = 0;
    while (!bus.o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_eq("ready_timeout", 64'(bus.o_ready), 1);
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask

  task automatic start_pulse();
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  // Full scan of tgt[]; rnd splits each angle's total randomly across samples,
  // stress adds valid gaps plus start/valid asserted during COMPARE.
  task automatic run_scan(input bit rnd, input bit stress, input bit hold_chk);
    logic [63:0] samp [NA][NS];
    logic [63:0] part, best_p, best_a;
    best_p = 0;
    best_a = 0;
    for (int a = 0; a < int'(NA); a++) begin
      part = 0;
      for (int s = 0; s < int'(NS); s++) begin
        if (s == int'(NS) - 1) samp[a][s] = tgt[a] - part;
        else if (rnd) samp[a][s] = 64'($urandom_range(0, 32'(tgt[a] / NS)));
        else samp[a][s] = tgt[a] / NS;
        part += samp[a][s];
      end
      if (a == 0 || tgt[a] > best_p) begin
        best_p = tgt[a];
        best_a = 64'(a);
      end
    end
    bq.push_back('{best_a, best_p});
    start_pulse();
    check_eq("busy_after_start", 64'(bus.o_busy), 1);
    check_eq("ready_after_start", 64'(bus.o_ready), 1);
    if (hold_chk) begin
      check_eq("best_angle_hold", 64'(bus.o_best_angle), last_best_a);
      check_eq("best_power_hold", 64'(bus.o_best_power), last_best_p);
    end
    for (int a = 0; a < int'(NA); a++) begin
      for (int s = 0; s < int'(NS); s++) begin
        if (s == int'(NS) - 1) pq.push_back('{64'(a), tgt[a]});
        push(samp[a][s], stress && !(s == 0 && a != 0));
      end
      check_eq("pow_latency", 64'(bus.o_pow_valid), 1);
      check_eq("ready_in_compare", 64'(bus.o_ready), 0);
      if (stress && a < int'(NA) - 1) begin
        bus.i_valid = 1'b1;
        bus.i_data  = DW'(samp[a+1][0]);
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        check_eq("busy_thru_compare", 64'(bus.o_busy), 1);
      end
    end
    @(negedge clk);
    check_eq("done_latency", 64'(bus.o_done), 1);
    @(negedge clk);
    check_eq("done_one_pulse", 64'(bus.o_done), 0);
    check_eq("busy_after_done", 64'(bus.o_busy), 0);
    check_eq("best_angle_held", 64'(bus.o_best_angle), best_a);
    check_eq("best_power_held", 64'(bus.o_best_power), best_p);
    last_best_a = best_a;
    last_best_p = best_p;
  endtask

  function automatic logic [63:0] outs_or();
    return 64'(|{bus.o_ready, bus.o_busy, bus.o_pow_valid, bus.o_pow_angle, bus.o_pow_data,
                 bus.o_done, bus.o_best_angle, bus.o_best_power});
  endfunction

  initial begin
    logic [63:0] model;
    int k, n;
    int unsigned dc;
    rst = 1'b1;
    bus.i_start = 1'b0; bus.i_valid = 1'b0; bus.i_data = '0;
    bus_s.i_start = 1'b0; bus_s.i_valid = 1'b0; bus_s.i_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 50; i++) begin
      check_eq("idle_outputs_zero", outs_or(), 0);
      @(negedge clk);
    end

    // 5: saturation on the narrow-accumulator instance
    check_eq("sat_reset_busy", 64'(bus_s.o_busy), 0);
    bus_s.i_start = 1'b1;
    @(negedge clk);
    bus_s.i_start = 1'b0;
    bus_s.i_valid = 1'b1;
    bus_s.i_data  = '1;
    model = 0; k = 0; n = 0;
    while (k < int'(NS) && n < 40) begin
      if (bus_s.o_ready) begin
        k++;
        model = model + ((64'd1 << DW) - 1);
        if (model > (64'd1 << SAT_AW) - 1) model = (64'd1 << SAT_AW) - 1;
      end
      @(negedge clk);
      n++;
    end
    bus_s.i_valid = 1'b0;
    check_eq("sat_pow_valid", 64'(bus_s.o_pow_valid), 1);
    check_eq("sat_pow_angle", 64'(bus_s.o_pow_angle), 0);
    check_eq("sat_pow_data", 64'(bus_s.o_pow_data), model);

    // 2: basic scan
    tgt = '{64'd80, 64'd160, 64'd240, 64'd320};
    run_scan(1'b0, 1'b0, 1'b0);

    // 3: tie keeps lower index; old best held during the new scan
    tgt = '{64'd50, 64'd90, 64'd90, 64'd10};
    run_scan(1'b1, 1'b0, 1'b1);

    // 4: gaps and ignored start / held sample across COMPARE
    tgt = '{64'd80, 64'd160, 64'd240, 64'd320};
    run_scan(1'b0, 1'b1, 1'b1);

    // 6: reset in the middle of angle 2, then a clean rescan
    start_pulse();
    for (int a = 0; a < 3; a++) begin
      for (int s = 0; s < int'(NS); s++) begin
        if (a == 2 && s == 3) break;
        if (s == int'(NS) - 1) pq.push_back('{64'(a), tgt[a]});
        push(tgt[a] / NS, 1'b0);
      end
    end
    dc = done_cnt;
    bus.i_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    rst = 1'b0;
    check_eq("abort_outputs_zero", outs_or(), 0);
    check_eq("abort_pow_queue", 64'(pq.size()), 0);
    repeat (10) @(negedge clk);
    check_eq("abort_no_done", 64'(done_cnt), 64'(dc));
    run_scan(1'b0, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    check_eq("pow_queue_drained", 64'(pq.size()), 0);
    check_eq("done_queue_drained", 64'(bq.size()), 0);
    check_eq("done_count", 64'(done_cnt), 4);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
